// File: rtl/seg_scan.sv
// seg_scan: 5-digit multiplexed seven-segment scanner with per-frame latching and flash.
// Optional anti-ghosting dead time per digit is enabled by defining SEG_BLANK_EN.
module seg_scan #(
    parameter int DIGIT_DIV  = 4000,
    parameter int FLASH_HALF = 250,
    parameter int BLANK_CYC  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [39:0] data_in,
    input  logic [2:0]  mode_in,
    output logic [4:0]  digit_sel,
    output logic [7:0]  seg_out,
    output logic [2:0]  flash_cnt
);

    localparam int DW = $clog2(DIGIT_DIV);
    localparam int FW = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;

    localparam logic [DW-1:0] DIV_LAST   = DW'(DIGIT_DIV - 1);
    localparam logic [DW-1:0] BLANK_LEN  = DW'(BLANK_CYC);
    localparam logic [FW-1:0] HALF_LAST  = FW'(FLASH_HALF - 1);
    localparam logic [2:0]    LAST_DIG   = 3'd4;
    localparam logic [2:0]    FC_MAX     = 3'd7;

`ifdef SEG_BLANK_EN
    localparam bit BLANK_EN = 1'b1;
`else
    localparam bit BLANK_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        MODE_CONST = 2'd0,
        MODE_FLASH = 2'd1,
        MODE_BLANK = 2'd2
    } mode_t;

    typedef enum logic {
        PH_ON  = 1'b0,
        PH_OFF = 1'b1
    } phase_t;

    // Unlisted mode codes fall back to a steady display.
    function automatic mode_t decode_mode(input logic [2:0] m);
        mode_t r;
        case (m)
            3'd1:    r = MODE_FLASH;
            3'd2:    r = MODE_BLANK;
            default: r = MODE_CONST;
        endcase
        return r;
    endfunction

    // Scan state
    logic          started;
    logic [DW-1:0] div_cnt;
    logic [2:0]    dig;

    // Frame-latched display content
    logic [39:0]   frame_data;
    mode_t         frame_mode;

    // Flash engine state
    logic [FW-1:0] frame_cnt;
    phase_t        phase;

    // Next-state values
    logic          div_wrap;
    logic          frame_start;
    logic [DW-1:0] div_nxt;
    logic [2:0]    dig_nxt;
    logic [39:0]   data_nxt;
    mode_t         mode_nxt;
    logic [FW-1:0] cnt_nxt;
    phase_t        phase_nxt;
    logic [2:0]    fc_nxt;
    logic [7:0]    byte_nxt;
    logic          dark;
    logic          dead;
    logic [4:0]    sel_nxt;
    logic [7:0]    seg_nxt;

    // Divider and digit index; the first edge out of reset opens a frame.
    always_comb begin
        div_wrap    = (div_cnt == DIV_LAST);
        div_nxt     = div_cnt;
        dig_nxt     = dig;
        frame_start = 1'b0;
        if (!started) begin
            div_nxt     = '0;
            dig_nxt     = '0;
            frame_start = 1'b1;
        end else if (div_wrap) begin
            div_nxt = '0;
            if (dig == LAST_DIG) begin
                dig_nxt     = '0;
                frame_start = 1'b1;
            end else begin
                dig_nxt = dig + 3'd1;
            end
        end else begin
            div_nxt = div_cnt + 1'b1;
        end
    end

    // Latch content at frame start and advance the flash sequence.
    always_comb begin
        data_nxt  = frame_data;
        mode_nxt  = frame_mode;
        cnt_nxt   = frame_cnt;
        phase_nxt = phase;
        fc_nxt    = flash_cnt;
        if (frame_start) begin
            data_nxt = data_in;
            mode_nxt = decode_mode(mode_in);
            if (mode_nxt != MODE_FLASH || frame_mode != MODE_FLASH) begin
                // Entering or outside flash: sequence restarts lit.
                cnt_nxt   = '0;
                phase_nxt = PH_ON;
                fc_nxt    = '0;
            end else if (frame_cnt == HALF_LAST) begin
                cnt_nxt   = '0;
                phase_nxt = (phase == PH_ON) ? PH_OFF : PH_ON;
                if (phase == PH_OFF && flash_cnt != FC_MAX) begin
                    fc_nxt = flash_cnt + 3'd1;
                end
            end else begin
                cnt_nxt = frame_cnt + 1'b1;
            end
        end
    end

    // Pick the byte for the digit about to be driven and gate it.
    always_comb begin
        unique case (dig_nxt)
            3'd0:    byte_nxt = data_nxt[39:32];
            3'd1:    byte_nxt = data_nxt[31:24];
            3'd2:    byte_nxt = data_nxt[23:16];
            3'd3:    byte_nxt = data_nxt[15:8];
            default: byte_nxt = data_nxt[7:0];
        endcase
        dark = (mode_nxt == MODE_BLANK) ||
               (mode_nxt == MODE_FLASH && phase_nxt == PH_OFF);
        dead = BLANK_EN && (div_nxt < BLANK_LEN);
        sel_nxt = 5'b00001 << dig_nxt;
        seg_nxt = dark ? 8'h00 : byte_nxt;
        if (dead) begin
            sel_nxt = 5'b00000;
            seg_nxt = 8'h00;
        end
    end

    // Scan counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            started <= 1'b0;
            div_cnt <= '0;
            dig     <= '0;
        end else begin
            started <= 1'b1;
            div_cnt <= div_nxt;
            dig     <= dig_nxt;
        end
    end

    // Frame-latched content and flash engine.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_data <= '0;
            frame_mode <= MODE_CONST;
            frame_cnt  <= '0;
            phase      <= PH_ON;
            flash_cnt  <= '0;
        end else begin
            frame_data <= data_nxt;
            frame_mode <= mode_nxt;
            frame_cnt  <= cnt_nxt;
            phase      <= phase_nxt;
            flash_cnt  <= fc_nxt;
        end
    end

    // Registered pin drive.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digit_sel <= '0;
            seg_out   <= '0;
        end else begin
            digit_sel <= sel_nxt;
            seg_out   <= seg_nxt;
        end
    end

endmodule

// File: tb/tb_seg_scan.sv
// tb_seg_scan: randomized and directed stimulus for seg_scan against a
// frame-level reference model (frames counted since flash entry).
module tb_seg_scan;

    localparam int DIV   = 4;
    localparam int FH    = 2;
    localparam int BLANK = 2;
    localparam int FRAME = 5 * DIV;

    logic        clk;
    logic        reset;
    logic [39:0] data_in;
    logic [2:0]  mode_in;
    logic [4:0]  digit_sel;
    logic [7:0]  seg_out;
    logic [2:0]  flash_cnt;

    int checks;
    int errors;

    // Reference model state
    int          k;
    logic [39:0] m_data;
    int          m_mode;
    int          m_frames;

    seg_scan #(
        .DIGIT_DIV (DIV),
        .FLASH_HALF(FH),
        .BLANK_CYC (BLANK)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .data_in  (data_in),
        .mode_in  (mode_in),
        .digit_sel(digit_sel),
        .seg_out  (seg_out),
        .flash_cnt(flash_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [39:0] obs,
                       input logic [39:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        k        = 0;
        m_data   = '0;
        m_mode   = 0;
        m_frames = 0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_sel"}, {35'd0, digit_sel}, 40'd0);
        chk({tag, "_seg"}, {32'd0, seg_out}, 40'd0);
        chk({tag, "_fc"}, {37'd0, flash_cnt}, 40'd0);
    endtask

    // One clock edge: advance the model with the inputs seen at the edge.
    task automatic tick();
        int         pos;
        int         d;
        int         nm;
        int         fc;
        bit         on;
        logic [4:0] e_sel;
        logic [7:0] e_seg;
        @(posedge clk);
        #1;
        if (reset) begin
            check_zero("in_reset");
            return;
        end
        k++;
        pos = (k - 1) % FRAME;
        if (pos == 0) begin
            nm = (mode_in == 3'd1) ? 1 : (mode_in == 3'd2) ? 2 : 0;
            if (nm == 1 && m_mode == 1) m_frames++;
            else m_frames = 0;
            m_mode = nm;
            m_data = data_in;
        end
        d     = pos / DIV;
        e_sel = 5'(1 << d);
        on    = (m_mode == 0) || (m_mode == 1 && ((m_frames / FH) % 2) == 0);
        e_seg = on ? 8'(m_data >> (8 * (4 - d))) : 8'h00;
        fc    = (m_mode == 1) ? m_frames / (2 * FH) : 0;
        if (fc > 7) fc = 7;
`ifdef SEG_BLANK_EN
        if (((k - 1) % DIV) < BLANK) begin
            e_sel = 5'd0;
            e_seg = 8'h00;
        end
`endif
        chk("digit_sel", {35'd0, digit_sel}, {35'd0, e_sel});
        chk("seg_out", {32'd0, seg_out}, {32'd0, e_seg});
        chk("flash_cnt", {37'd0, flash_cnt}, 40'(fc));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check_zero("reset");
        run(2);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset   = 1'b1;
        data_in = '0;
        mode_in = 3'd0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Steady digits, then a mid-frame change that must wait for the frame.
        data_in = 40'h73_06_40_3F_06;
        run(6);
        data_in = 40'hFF_FF_FF_FF_FF;
        run(34);

        // Flash from constant data, long enough to saturate.
        data_in = 40'h73_06_40_3F_06;
        mode_in = 3'd1;
        run(700);
        mode_in = 3'd0;
        run(30);

        // Leave flash at flash_cnt=3, then return.
        do_reset();
        mode_in = 3'd1;
        run(250);
        mode_in = 3'd0;
        run(25);
        mode_in = 3'd1;
        run(100);

        // Blank mode and an unlisted code.
        mode_in = 3'd2;
        run(45);
        mode_in = 3'd5;
        run(45);

        // Asynchronous reset during an OFF phase, mid-digit.
        do_reset();
        mode_in = 3'd1;
        run(50);
        #2;
        reset = 1'b1;
        #1;
        check_zero("async_reset");
        run(2);
        reset = 1'b0;
        model_reset();
        run(60);

        // Randomized modes, durations and per-cycle data.
        for (int it = 0; it < 150; it++) begin
            int n;
            if ($urandom_range(0, 1) == 1) mode_in = 3'd1;
            else mode_in = 3'($urandom_range(0, 7));
            n = ($urandom_range(0, 5) == 0) ? $urandom_range(300, 800)
                                            : $urandom_range(1, 120);
            for (int c = 0; c < n; c++) begin
                if ($urandom_range(0, 3) == 0)
                    data_in = {8'($urandom), 32'($urandom)};
                tick();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_scan.md
# seg_scan

Multiplexed 5-digit seven-segment display driver: the consumer side of the key/menu front-end's display word. It latches the 40-bit segment word and display mode once per frame and scans one digit at a time. It applies flashing and reports completed flash cycles back to the front-end on `flash_cnt`, which the front-end uses to end its start-up splash. Sits between the front-end and the board's digit and segment pins.

## Interface
- `DIGIT_DIV`, 4000: clock cycles each digit is driven; 200 µs at 20 MHz, giving a 1 ms frame. Must be ≥ 2.
- `FLASH_HALF`, 250: frames per flash half-period, i.e. 250 ms on / 250 ms off. Must be ≥ 1.
- `BLANK_CYC`, 2: dead-time cycles per digit. Used only with `SEG_BLANK_EN`. Must be < `DIGIT_DIV`.
- `clk` in 1: 20 MHz system clock. One clock domain. Reset is asynchronous and active-high.
- `reset` in 1: asynchronous, active-high reset.
- `data_in` in 40: segment word. Digit 0 is `[39:32]` (leftmost) through digit 4 `[7:0]`. Bit 7 is the decimal point and bits 6:0 are segments g..a.
- `mode_in` in 3: 3'd0 constant, 3'd1 flash, 3'd2 blank. Any other code behaves as constant.
- `digit_sel` out 5: one-hot digit enable, active-high.
- `seg_out` out 8: segment drive, active-high, for the selected digit.
- `flash_cnt` out 3: completed flash cycles since flash mode was entered. Saturates at 7.

## Operation
- Divider `div_cnt` runs 0..`DIGIT_DIV`-1. When it wraps, digit index `dig` advances 0→1→2→3→4→0.
- Frame start is `dig` wrapping to 0, plus the first edge after reset release. At frame start, `data_in` and `mode_in` are latched into `frame_data` and `frame_mode`. Changes mid-frame are never visible until the next frame (no tearing).
- Outputs are registered.
  - `digit_sel` = 1 << `dig`.
  - `seg_out` = byte `dig` of `frame_data`, gated by mode and flash phase.
- Flash engine (active only while `frame_mode`==flash):
  - `frame_cnt` counts frames 0..`FLASH_HALF`-1.
  - When `frame_cnt` wraps, `phase` toggles ON↔OFF.
  - On each OFF→ON toggle, `flash_cnt` += 1, saturating at 7.
  - During OFF, `seg_out`=8'h00 while `digit_sel` keeps scanning.
- Entering flash: `frame_mode` changes from non-flash to flash at a frame start. That same frame starts with `phase`=ON, `frame_cnt`=0 and `flash_cnt`=0.
- Leaving flash: `frame_mode` becomes non-flash. `phase` is forced ON, while `frame_cnt` and `flash_cnt` hold 0.
- Re-latching flash while already in flash does not restart the sequence.
- Blank mode: `seg_out`=8'h00 for the whole frame and `digit_sel` still scans.
- Simultaneous events: a flash toggle and a mode change landing on the same frame start resolve by mode. The new mode's entry rule wins.

## Timing
- Reset (asynchronous, any cycle, including mid-frame or mid-flash) sets:
  - `digit_sel`=5'b00000, `seg_out`=8'h00, `flash_cnt`=3'd0;
  - `div_cnt`=0, `dig`=0, `frame_cnt`=0, `phase`=ON;
  - `frame_data`=0, `frame_mode`=constant.
- First edge after reset release: latch inputs, and drive `digit_sel`=5'b00001 with `seg_out` taken from the value just latched.
- Each digit is held exactly `DIGIT_DIV` cycles. A frame is 5×`DIGIT_DIV` cycles.
- Input-to-pin latency: a `data_in` change is shown no later than the next frame start plus 1 cycle.
- `flash_cnt` updates on the same edge that `seg_out` returns from OFF to ON.
- No two `digit_sel` bits are ever high in the same cycle.

## Configuration
- `SEG_BLANK_EN` defined: for the first `BLANK_CYC` cycles of every digit dwell, `digit_sel`=5'b00000 and `seg_out`=8'h00. This is anti-ghosting dead time. The digit is then driven for `DIGIT_DIV`-`BLANK_CYC` cycles, and frame length is unchanged.
- `SEG_BLANK_EN` undefined: no dead time. `BLANK_CYC` is ignored, and each digit is driven for all `DIGIT_DIV` cycles.

## Test plan
All scenarios use `DIGIT_DIV`=4 and `FLASH_HALF`=2.
- Reset, then `data_in`=40'h73_06_40_3F_06 with mode 0 → sequence per 4 cycles:
  - `digit_sel` 00001/73, 00010/06, 00100/40, 01000/3F, 10000/06;
  - then repeats with period 20.
- Change `data_in` to all 8'hFF at cycle 7 (mid-frame) → `seg_out` keeps the old bytes until cycle 20. It shows FF from the next frame start.
- Mode 1 with constant data → ON for 2 frames (40 cycles), then OFF with `seg_out`=00 for 40 cycles.
  - `flash_cnt` steps 1,2,3,4 at cycles 80,160,240,320.
  - It saturates at 7 after cycle 560.
- While `flash_cnt`=3, switch to mode 0 and then back to 1 → `flash_cnt` reads 0 from the first constant frame. The flash sequence restarts ON with `flash_cnt`=0.
- Assert `reset` mid-digit during the OFF phase → all outputs are 0 within the same cycle, without waiting for a clock edge. After release, the scan restarts at digit 0 with `flash_cnt`=0.
- With `SEG_BLANK_EN` and `BLANK_CYC`=2 → in each 4-cycle dwell, `digit_sel`=0 for 2 cycles and the digit is driven for 2. Frame period stays 20 cycles.
